// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the result-entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Used by issue, the decoder, alu_fork_pipe and alu_result_fifo.
package alu_pkg;

    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_ADD  = 4'b1111;

    // Default pipe geometry; alu_entry_t is laid out for these widths.
    localparam int ALU_XLEN    = 32;
    localparam int ALU_TAG_W   = 4;
    localparam int ALU_AREG_W  = 5;
    localparam int ALU_NUM_DST = 4;

    // One buffered result. done[i] set means consumer i needs nothing more.
    typedef struct packed {
        logic [ALU_XLEN-1:0]    result;
        logic [ALU_TAG_W-1:0]   tag;
        logic [ALU_AREG_W-1:0]  areg;
        logic [ALU_NUM_DST-1:0] done;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO with per-consumer delivery: the head is offered to every consumer whose done bit is clear.
// Latency: a write at edge N is visible at the head after edge N when the FIFO was empty.
// Backpressure: the head retires only when all consumers have taken it; writes are dropped when full.
// Ports: wrEn/wrDat/wrMask write the tail (done = ~wrMask); rdValid/rdReady are per-consumer
// handshakes on the head; rdDat is the head payload (0 when empty); flush empties the FIFO.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DAT_W   = ALU_XLEN + ALU_TAG_W + ALU_AREG_W,
    parameter int NUM_DST = ALU_NUM_DST,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wrEn,
    input  logic [DAT_W-1:0]           wrDat,
    input  logic [NUM_DST-1:0]         wrMask,
    input  logic [NUM_DST-1:0]         rdReady,
    output logic [NUM_DST-1:0]         rdValid,
    output logic [DAT_W-1:0]           rdDat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DAT_W-1:0]   datMem  [DEPTH];
    logic [NUM_DST-1:0] doneMem [DEPTH];
    logic [PTR_W-1:0]   headPtr;
    logic [PTR_W-1:0]   tailPtr;

    logic               notEmpty;
    logic               wrOk;
    logic               retire;
    logic [NUM_DST-1:0] takes;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        notEmpty = (count != '0);
        wrOk     = wrEn && !flush && (count != CNT_W'(DEPTH));
        rdValid  = notEmpty ? ~doneMem[headPtr] : '0;
        rdDat    = notEmpty ? datMem[headPtr] : '0;
        takes    = rdValid & rdReady;
        // Retire on the cycle the last outstanding consumer takes, not the cycle after.
        retire   = notEmpty && (&(doneMem[headPtr] | takes));
    end

    // Payload needs no reset: it is only observable while count is non-zero.
    always_ff @(posedge clk) begin
        if (wrOk) begin
            datMem[tailPtr] <= wrDat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                doneMem[i] <= '0;
            end
        end else if (flush) begin
            count   <= '0;
            headPtr <= '0;
            tailPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                doneMem[i] <= '0;
            end
        end else begin
            if (retire) begin
                headPtr <= ptrInc(headPtr);
            end else begin
                doneMem[headPtr] <= doneMem[headPtr] | takes;
            end
            // head == tail with a write only happens when empty, where takes is zero;
            // this later assignment wins either way.
            if (wrOk) begin
                doneMem[tailPtr] <= ~wrMask;
                tailPtr          <= ptrInc(tailPtr);
            end
            if (wrOk && !retire) begin
                count <= count + CNT_W'(1);
            end else if (!wrOk && retire) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_fork_pipe.sv
// Integer ALU stage feeding a result FIFO that forks each result to up to NUM_DST consumers.
// Latency: 1 cycle from accept to head of an empty FIFO; 1 op/cycle with DEPTH >= 2.
// Backpressure: in_ready depends only on count; a stalled consumer blocks retirement only.
// Ports: in_* is the issue handshake plus operands; out_valid/out_ready are per-consumer;
// out_result/out_tag/out_areg are the shared head fields (0 when empty); flush kills all work.
module alu_fork_pipe
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int AREG_W  = 5,
    parameter int NUM_DST = 4,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [XLEN-1:0]            in_opa,
    input  logic [XLEN-1:0]            in_opb,
    input  logic [AREG_W-1:0]          in_areg,
    input  logic [NUM_DST-1:0]         in_dst_mask,
    input  logic                       flush,
    output logic [NUM_DST-1:0]         out_valid,
    input  logic [NUM_DST-1:0]         out_ready,
    output logic [XLEN-1:0]            out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [AREG_W-1:0]          out_areg,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SH_W  = $clog2(XLEN);
    localparam int DAT_W = XLEN + TAG_W + AREG_W;

    logic [XLEN-1:0]  aluRes;
    logic [SH_W-1:0]  shAmt;
    logic             accept;
    logic             wrEn;
    logic [DAT_W-1:0] headDat;

    always_comb begin
        shAmt  = in_opb[SH_W-1:0];
        aluRes = '0;
        case (in_op)
            OP_ADD:  aluRes = in_opa + in_opb;
            OP_SUB:  aluRes = in_opa - in_opb;
            OP_SLT:  aluRes = {{(XLEN-1){1'b0}}, ($signed(in_opa) < $signed(in_opb))};
            OP_SLTU: aluRes = {{(XLEN-1){1'b0}}, (in_opa < in_opb)};
            OP_AND:  aluRes = in_opa & in_opb;
            OP_OR:   aluRes = in_opa | in_opb;
            OP_XOR:  aluRes = in_opa ^ in_opb;
            OP_SRA:  aluRes = $unsigned($signed(in_opa) >>> shAmt);
            OP_SLL:  aluRes = in_opa << shAmt;
            OP_SRL:  aluRes = in_opa >> shAmt;
            OP_LUI:  aluRes = in_opb;
            default: aluRes = '0;
        endcase
    end

    // An op with an empty destination mask is consumed here and never buffered.
    always_comb begin
        in_ready = (count < CNT_W'(DEPTH)) && !rst;
        accept   = in_valid && in_ready && !flush;
        wrEn     = accept && (|in_dst_mask);
    end

    alu_result_fifo #(
        .DAT_W   (DAT_W),
        .NUM_DST (NUM_DST),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wrEn    (wrEn),
        .wrDat   ({aluRes, in_tag, in_areg}),
        .wrMask  (in_dst_mask),
        .rdReady (out_ready),
        .rdValid (out_valid),
        .rdDat   (headDat),
        .count   (count)
    );

    assign {out_result, out_tag, out_areg} = headDat;

endmodule

// File: tb/tb_alu_fork_pipe.sv
module tb_alu_fork_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [3:0]  in_tag;
    logic [31:0] in_opa;
    logic [31:0] in_opb;
    logic [4:0]  in_areg;
    logic [3:0]  in_dst_mask;
    logic        flush;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic [4:0]  out_areg;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    alu_fork_pipe #(
        .XLEN(32), .TAG_W(4), .AREG_W(5), .NUM_DST(4), .DEPTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .in_opa      (in_opa),
        .in_opb      (in_opb),
        .in_areg     (in_areg),
        .in_dst_mask (in_dst_mask),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_areg    (out_areg),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer-0 delivery log: {tag, result} for every handshake, sampled mid-cycle.
    logic [35:0] takeLog [$];
    always @(negedge clk) begin
        if (!rst && out_valid[0] && out_ready[0]) begin
            takeLog.push_back({out_tag, out_result});
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [4:0]  areg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; all drives and checks happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [4:0] areg, input logic [3:0] mask);
        in_valid    = 1'b1;
        in_op       = op;
        in_opa      = a;
        in_opb      = b;
        in_tag      = tag;
        in_areg     = areg;
        in_dst_mask = mask;
    endtask

    initial begin
        vecs[0]  = '{"add_wrap", 4'b1111, 32'hFFFF_FFFF, 32'h1,         4'h1, 5'd1,  32'h0};
        vecs[1]  = '{"sub_wrap", 4'b0001, 32'h0,         32'h1,         4'h2, 5'd2,  32'hFFFF_FFFF};
        vecs[2]  = '{"slt",      4'b0010, 32'h8000_0000, 32'h1,         4'h3, 5'd3,  32'h1};
        vecs[3]  = '{"sltu",     4'b0011, 32'h8000_0000, 32'h1,         4'h4, 5'd4,  32'h0};
        vecs[4]  = '{"sra",      4'b0111, 32'h8000_0000, 32'h4,         4'h5, 5'd5,  32'hF800_0000};
        vecs[5]  = '{"srl",      4'b1001, 32'h8000_0000, 32'h4,         4'h6, 5'd6,  32'h0800_0000};
        vecs[6]  = '{"sll33",    4'b1000, 32'h1,         32'd33,        4'h7, 5'd7,  32'h2};
        vecs[7]  = '{"lui",      4'b1010, 32'hDEAD_BEEF, 32'h1234_5000, 4'h8, 5'd8,  32'h1234_5000};
        vecs[8]  = '{"op1100",   4'b1100, 32'h5,         32'h7,         4'h9, 5'd9,  32'h0};
        vecs[9]  = '{"and",      4'b0100, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'hA, 5'd10, 32'h0F00_0F00};
        vecs[10] = '{"or",       4'b0101, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'hB, 5'd11, 32'hFFF0_FFF0};
        vecs[11] = '{"xor",      4'b0110, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'hC, 5'd31, 32'hF0F0_F0F0};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_tag = '0; in_opa = '0; in_opb = '0;
        in_areg = '0; in_dst_mask = '0; flush = 1'b0; out_ready = '0;
        tick(); tick();
        chk("rst_out_valid", 36'(out_valid), 36'h0);
        chk("rst_count",     36'(count), 36'h0);
        chk("rst_in_ready",  36'(in_ready), 36'h0);
        chk("rst_result",    36'(out_result), 36'h0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 36'(in_ready), 36'h1);
        tick();

        // Single-op vectors, every consumer ready: visible one edge later, gone the next.
        out_ready = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].areg, 4'b1111);
            tick();
            in_valid = 1'b0;
            chk({vecs[i].name, "_valid"},  36'(out_valid), 36'hF);
            chk({vecs[i].name, "_result"}, 36'(out_result), 36'(vecs[i].exp));
            chk({vecs[i].name, "_tag"},    36'(out_tag), 36'(vecs[i].tag));
            chk({vecs[i].name, "_areg"},   36'(out_areg), 36'(vecs[i].areg));
            tick();
            chk({vecs[i].name, "_retired"}, 36'(count), 36'h0);
        end

        // Partial fork: mask 1011, consumer 3 stalled for 5 cycles.
        out_ready = 4'b0011;
        drive(4'b1111, 32'd5, 32'd6, 4'hA, 5'd7, 4'b1011);
        tick();
        in_valid = 1'b0;
        chk("fork_valid0",  36'(out_valid), 36'hB);
        chk("fork_result",  36'(out_result), 36'd11);
        tick();
        chk("fork_valid1",  36'(out_valid), 36'h8);
        chk("fork_count1",  36'(count), 36'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fork_stall_valid", 36'(out_valid), 36'h8);
            chk("fork_stall_count", 36'(count), 36'h1);
        end
        out_ready = 4'b1011;
        tick();
        chk("fork_ret_count", 36'(count), 36'h0);
        chk("fork_ret_valid", 36'(out_valid), 36'h0);

        // Backpressure: three back-to-back ops, nobody ready.
        takeLog.delete();
        out_ready = 4'b0000;
        drive(4'b1111, 32'd1, 32'd1, 4'd1, 5'd1, 4'b1111);
        tick();
        drive(4'b1111, 32'd2, 32'd2, 4'd2, 5'd2, 4'b1111);
        tick();
        drive(4'b1111, 32'd3, 32'd3, 4'd3, 5'd3, 4'b1111);
        tick();
        chk("bp_count_full", 36'(count), 36'h2);
        chk("bp_in_ready",   36'(in_ready), 36'h0);
        chk("bp_head_tag",   36'(out_tag), 36'h1);
        tick();
        chk("bp_held_count", 36'(count), 36'h2);
        out_ready = 4'b1111;
        tick();
        chk("bp_rel_count",    36'(count), 36'h1);
        chk("bp_rel_in_ready", 36'(in_ready), 36'h1);
        chk("bp_rel_tag",      36'(out_tag), 36'h2);
        tick();
        in_valid = 1'b0;
        chk("bp_swap_count", 36'(count), 36'h1);
        chk("bp_swap_tag",   36'(out_tag), 36'h3);
        tick();
        chk("bp_drain_count", 36'(count), 36'h0);

        // Empty-mask op sandwiched between two normal ops.
        drive(4'b1111, 32'd4, 32'd4, 4'd4, 5'd4, 4'b1111);
        tick();
        drive(4'b1111, 32'd5, 32'd5, 4'd5, 5'd5, 4'b0000);
        tick();
        chk("m0_count", 36'(count), 36'h0);
        drive(4'b1111, 32'd6, 32'd6, 4'd6, 5'd6, 4'b1111);
        tick();
        in_valid = 1'b0;
        chk("m0_tag6",   36'(out_tag), 36'h6);
        chk("m0_count6", 36'(count), 36'h1);
        tick();

        // Flush with the FIFO full and an op presented.
        out_ready = 4'b0000;
        drive(4'b1111, 32'd7, 32'd7, 4'd7, 5'd7, 4'b1111);
        tick();
        drive(4'b1111, 32'd8, 32'd8, 4'd8, 5'd8, 4'b1111);
        tick();
        chk("fl_full", 36'(count), 36'h2);
        drive(4'b1111, 32'd9, 32'd9, 4'd9, 5'd9, 4'b1111);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count",    36'(count), 36'h0);
        chk("fl_valid",    36'(out_valid), 36'h0);
        chk("fl_in_ready", 36'(in_ready), 36'h1);
        // Flush with room: the op presented alongside must still be dropped.
        drive(4'b1111, 32'd10, 32'd10, 4'd10, 5'd10, 4'b1111);
        tick();
        drive(4'b1111, 32'd11, 32'd11, 4'd11, 5'd11, 4'b1111);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl2_count", 36'(count), 36'h0);
        chk("fl2_valid", 36'(out_valid), 36'h0);
        drive(4'b1111, 32'd12, 32'd12, 4'd12, 5'd12, 4'b1111);
        tick();
        in_valid = 1'b0;
        chk("fl_after_tag",   36'(out_tag), 36'd12);
        chk("fl_after_valid", 36'(out_valid), 36'hF);
        out_ready = 4'b1111;
        tick();
        chk("fl_after_drain", 36'(count), 36'h0);

        // Delivery order and content seen by consumer 0 since the backpressure test.
        chk("log_size", 36'(takeLog.size()), 36'd6);
        if (takeLog.size() == 6) begin
            chk("log0", takeLog[0], {4'd1,  32'd2});
            chk("log1", takeLog[1], {4'd2,  32'd4});
            chk("log2", takeLog[2], {4'd3,  32'd6});
            chk("log3", takeLog[3], {4'd4,  32'd8});
            chk("log4", takeLog[4], {4'd6,  32'd12});
            chk("log5", takeLog[5], {4'd12, 32'd24});
        end

        // Asynchronous reset with an entry buffered: dropped immediately, never replayed.
        out_ready = 4'b0000;
        drive(4'b1111, 32'd13, 32'd13, 4'd13, 5'd13, 4'b1111);
        tick();
        in_valid = 1'b0;
        chk("mr_pre_count", 36'(count), 36'h1);
        rst = 1'b1;
        #1;
        chk("mr_valid",    36'(out_valid), 36'h0);
        chk("mr_count",    36'(count), 36'h0);
        chk("mr_in_ready", 36'(in_ready), 36'h0);
        chk("mr_tag",      36'(out_tag), 36'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_rel_in_ready", 36'(in_ready), 36'h1);
        out_ready = 4'b1111;
        tick();
        chk("mr_no_replay_valid", 36'(out_valid), 36'h0);
        chk("mr_no_replay_count", 36'(count), 36'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
